// File: rtl/decoder_n_leaf.sv
// decoder_n_leaf: NoC routing decoder that sends a select token and then the flit
// to one of NUM_OUT down-ports or the uplink, with a 2-entry input FIFO.
module decoder_n_leaf #(
  parameter int DATA_W = 9,
  parameter int ADDR_LSB = 5,
  parameter int ADDR_W = 4,
  parameter int NUM_OUT = 2,
  parameter int IDX_LSB = 2,
  parameter logic [ADDR_W-1:0] BASE = 4'b1000,
  parameter logic [ADDR_W-1:0] MASK = 4'b1000
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [$clog2(NUM_OUT+1)-1:0] sel_data,
  output logic                         sel_valid,
  input  logic                         sel_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [NUM_OUT:0]             out_valid,
  input  logic [NUM_OUT:0]             out_ready,
  output logic [15:0]                  up_count
);
  localparam int SEL_W = $clog2(NUM_OUT+1);
  localparam int IDX_W = $clog2(NUM_OUT);
  typedef enum logic [1:0] {IDLE, SEL, DATA} state_t;
  state_t state, state_d;
  logic [DATA_W-1:0] mem [2];
  logic wr_ptr, rd_ptr, push, pop, more;
  logic [1:0] cnt;
  logic [SEL_W-1:0] route_q, route_d;
  logic [DATA_W-1:0] head, nxt;
  function automatic logic [SEL_W-1:0] route(input logic [DATA_W-1:0] d);
    logic [ADDR_W-1:0] a;
    a = d[ADDR_LSB +: ADDR_W];
    return ((a & MASK) != BASE) ? SEL_W'(NUM_OUT) : SEL_W'(a[IDX_LSB +: IDX_W]);
  endfunction
  assign head = mem[rd_ptr];
  assign in_ready = cnt != 2'd2;
  assign push = in_valid & in_ready;
  // after a pop the new head is either the second entry or the flit entering this cycle
  assign more = (cnt == 2'd2) | push;
  assign nxt = (cnt == 2'd2) ? mem[~rd_ptr] : in_data;
  assign sel_valid = state == SEL;
  assign sel_data = sel_valid ? route_q : '0;
  assign out_valid = (state == DATA) ? ((NUM_OUT+1)'(1) << route_q) : '0;
  assign out_data = (cnt != 2'd0) ? head : '0;
  always_comb begin
    state_d = state;
    route_d = route_q;
    pop = 1'b0;
    if (state == IDLE && cnt != 2'd0) begin
      state_d = SEL;
      route_d = route(head);
    end
    if (state == SEL && sel_ready) state_d = DATA;
    if (state == DATA && out_ready[route_q]) begin
      pop = 1'b1;
      state_d = more ? SEL : IDLE;
      route_d = more ? route(nxt) : route_q;
    end
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      route_q <= '0;
      cnt <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      up_count <= '0;
    end else begin
      state <= state_d;
      route_q <= route_d;
      cnt <= cnt + 2'(push) - 2'(pop);
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      if (pop && route_q == SEL_W'(NUM_OUT) && up_count != 16'hFFFF) up_count <= up_count + 16'd1;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_data;
  end
endmodule

// File: tb/tb_decoder_n_leaf.sv
// tb_decoder_n_leaf: directed and randomized checks of decoder_n_leaf against a
// queue-based reference model, on the default build and a 4-port build.
module tb_decoder_n_leaf;
  logic CLK = 1'b0, RESET = 1'b1;
  logic [8:0] in_data = '0, out_data;
  logic in_valid = 1'b0, in_ready, sel_valid, sel_ready = 1'b0;
  logic [1:0] sel_data;
  logic [2:0] out_valid, out_ready = '0;
  logic [15:0] up_count;
  logic [8:0] in_data4 = '0, out_data4;
  logic in_valid4 = 1'b0, in_ready4, sel_valid4, sel_ready4 = 1'b0;
  logic [2:0] sel_data4;
  logic [4:0] out_valid4, out_ready4 = '0;
  logic [15:0] up_count4;
  int n_checks = 0, n_fail = 0;

  decoder_n_leaf dut (
    .CLK(CLK), .RESET(RESET), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel_data(sel_data), .sel_valid(sel_valid), .sel_ready(sel_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .up_count(up_count)
  );
  decoder_n_leaf #(.NUM_OUT(4), .IDX_LSB(1)) dut4 (
    .CLK(CLK), .RESET(RESET), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .sel_data(sel_data4), .sel_valid(sel_valid4), .sel_ready(sel_ready4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .up_count(up_count4)
  );

  always #5 CLK = ~CLK;

  // Reference routing: address in bits 8:5; prefix 1xxx is local, anything else goes up.
  function automatic int ref_route(logic [8:0] d, int n, int idx_lsb);
    int a;
    a = (int'(d) >> 5) & 15;
    if ((a & 8) != 8) return n;
    return (a >> idx_lsb) % n;
  endfunction

  function automatic logic [8:0] mk(logic [3:0] a);
    return {a, 5'($urandom)};
  endfunction

  task automatic test_reset;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({in_ready, sel_valid, sel_data, out_valid, out_data, up_count} !== {1'b1, 1'b0, 2'b0, 3'b0, 9'b0, 16'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b sv=%b sd=%0d ov=%b od=%h up=%0d", in_ready, sel_valid, sel_data, out_valid, out_data, up_count);
    end
    n_checks++;
    if ({in_ready4, sel_valid4, sel_data4, out_valid4, out_data4, up_count4} !== {1'b1, 1'b0, 3'b0, 5'b0, 9'b0, 16'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs4: got rdy=%b sv=%b sd=%0d ov=%b od=%h", in_ready4, sel_valid4, sel_data4, out_valid4, out_data4);
    end
    RESET = 1'b0;
  endtask

  task automatic test_latency;
    logic [3:0] addrs [3] = '{4'b1010, 4'b1110, 4'b0110};
    logic [8:0] f;
    int r, up_exp;
    up_exp = 0;
    sel_ready = 1'b1;
    out_ready = '1;
    for (int i = 0; i < 3; i++) begin
      f = mk(addrs[i]);
      r = ref_route(f, 2, 2);
      if (r == 2) up_exp++;
      @(negedge CLK); in_data = f; in_valid = 1'b1;
      @(negedge CLK); in_valid = 1'b0;
      n_checks++;
      if ({sel_valid, out_valid, out_data} !== {1'b0, 3'b0, f}) begin
        n_fail++; $display("FAIL lat_head[%0d]: got sv=%b ov=%b od=%h want 0 0 %h", i, sel_valid, out_valid, out_data, f);
      end
      @(negedge CLK);
      n_checks++;
      if ({sel_valid, sel_data, out_valid} !== {1'b1, 2'(r), 3'b0}) begin
        n_fail++; $display("FAIL lat_sel[%0d]: got sv=%b sd=%0d ov=%b want 1 %0d 000", i, sel_valid, sel_data, out_valid, r);
      end
      @(negedge CLK);
      n_checks++;
      if ({sel_valid, out_valid, out_data} !== {1'b0, 3'(1 << r), f}) begin
        n_fail++; $display("FAIL lat_data[%0d]: got sv=%b ov=%b od=%h want 0 %b %h", i, sel_valid, out_valid, out_data, 3'(1 << r), f);
      end
      @(negedge CLK);
      n_checks++;
      if ({sel_valid, out_valid, out_data, in_ready, up_count} !== {1'b0, 3'b0, 9'b0, 1'b1, 16'(up_exp)}) begin
        n_fail++; $display("FAIL lat_done[%0d]: got sv=%b ov=%b od=%h rdy=%b up=%0d want up=%0d", i, sel_valid, out_valid, out_data, in_ready, up_count, up_exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [8:0] f [3];
    int cyc [3];
    int nd;
    logic acc;
    nd = 0;
    acc = 1'b0;
    for (int i = 0; i < 3; i++) f[i] = mk(4'($urandom));
    sel_ready = 1'b0;
    out_ready = '1;
    @(negedge CLK); in_data = f[0]; in_valid = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_first: got %b want 1", in_ready); end
    in_data = f[1];
    @(negedge CLK);
    in_data = f[2];
    for (int t = 0; t < 4; t++) begin
      n_checks++;
      if ({in_ready, sel_valid} !== 2'b01) begin
        n_fail++; $display("FAIL bp_full[%0d]: got rdy=%b sv=%b want 0 1", t, in_ready, sel_valid);
      end
      @(negedge CLK);
    end
    sel_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (acc) in_valid = 1'b0;
      acc = in_valid && in_ready;
      if (nd < 3 && (out_valid & out_ready) != 3'b0) begin
        n_checks++;
        if (out_data !== f[nd]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", nd, out_data, f[nd]); end
        cyc[nd] = t;
        nd++;
      end
      @(negedge CLK);
    end
    in_valid = 1'b0;
    n_checks++;
    if (nd !== 3) begin
      n_fail++; $display("FAIL bp_delivered: got %0d want 3", nd);
    end else begin
      n_checks++;
      if (cyc[1] - cyc[0] != 2 || cyc[2] - cyc[1] != 2) begin
        n_fail++; $display("FAIL bp_spacing: got %0d %0d want 2 2", cyc[1] - cyc[0], cyc[2] - cyc[1]);
      end
    end
  endtask

  task automatic test_hold;
    logic [8:0] f;
    int t;
    f = mk({2'b10, 2'($urandom)});
    sel_ready = 1'b1;
    out_ready = 3'b110;
    @(negedge CLK); in_data = f; in_valid = 1'b1;
    @(negedge CLK); in_valid = 1'b0;
    t = 0;
    while (out_valid == 3'b0 && t < 10) begin @(negedge CLK); t++; end
    n_checks++;
    if (out_valid !== 3'b001) begin n_fail++; $display("FAIL hold_start: got %b want 001", out_valid); end
    for (int i = 0; i < 5; i++) begin
      out_ready[1] = ~out_ready[1];
      @(negedge CLK);
      n_checks++;
      if ({out_valid, out_data, sel_valid} !== {3'b001, f, 1'b0}) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got ov=%b od=%h sv=%b want 001 %h 0", i, out_valid, out_data, sel_valid, f);
      end
    end
    out_ready = '1;
    @(negedge CLK);
    n_checks++;
    if ({out_valid, out_data} !== {3'b0, 9'b0}) begin
      n_fail++; $display("FAIL hold_release: got ov=%b od=%h want 000 0", out_valid, out_data);
    end
  endtask

  task automatic test_num_out4;
    logic [3:0] addrs [4] = '{4'b1101, 4'b0011, 4'b1000, 4'b1111};
    logic [8:0] f;
    int r;
    sel_ready4 = 1'b1;
    out_ready4 = '1;
    for (int i = 0; i < 4; i++) begin
      f = mk(addrs[i]);
      r = ref_route(f, 4, 1);
      @(negedge CLK); in_data4 = f; in_valid4 = 1'b1;
      @(negedge CLK); in_valid4 = 1'b0;
      @(negedge CLK);
      n_checks++;
      if ({sel_valid4, sel_data4} !== {1'b1, 3'(r)}) begin
        n_fail++; $display("FAIL n4_sel[%0d]: got sv=%b sd=%0d want 1 %0d", i, sel_valid4, sel_data4, r);
      end
      @(negedge CLK);
      n_checks++;
      if ({out_valid4, out_data4} !== {5'(1 << r), f}) begin
        n_fail++; $display("FAIL n4_data[%0d]: got ov=%b od=%h want %b %h", i, out_valid4, out_data4, 5'(1 << r), f);
      end
      @(negedge CLK);
    end
    n_checks++;
    if (up_count4 !== 16'd1) begin n_fail++; $display("FAIL n4_up_count: got %0d want 1", up_count4); end
  endtask

  task automatic test_reset_mid;
    logic [8:0] f0, f1, f2;
    f0 = mk(4'b1010);
    f1 = mk(4'b1110);
    f2 = mk(4'b1110);
    sel_ready = 1'b1;
    out_ready = '0;
    @(negedge CLK); in_data = f0; in_valid = 1'b1;
    @(negedge CLK); in_data = f1;
    @(negedge CLK); in_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({out_valid, in_ready} !== {3'b001, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_pre: got ov=%b rdy=%b want 001 0", out_valid, in_ready);
    end
    #2 RESET = 1'b1;
    #1;
    n_checks++;
    if ({in_ready, sel_valid, sel_data, out_valid, out_data, up_count} !== {1'b1, 1'b0, 2'b0, 3'b0, 9'b0, 16'b0}) begin
      n_fail++;
      $display("FAIL rst_mid_async: got rdy=%b sv=%b sd=%0d ov=%b od=%h up=%0d", in_ready, sel_valid, sel_data, out_valid, out_data, up_count);
    end
    @(negedge CLK);
    RESET = 1'b0;
    out_ready = '1;
    in_data = f2;
    in_valid = 1'b1;
    @(negedge CLK); in_valid = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({sel_valid, sel_data} !== {1'b1, 2'd1}) begin
      n_fail++; $display("FAIL rst_mid_sel: got sv=%b sd=%0d want 1 1", sel_valid, sel_data);
    end
    @(negedge CLK);
    n_checks++;
    if ({out_valid, out_data} !== {3'b010, f2}) begin
      n_fail++; $display("FAIL rst_mid_data: got ov=%b od=%h want 010 %h", out_valid, out_data, f2);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      n_checks++;
      if ({sel_valid, out_valid, out_data} !== {1'b0, 3'b0, 9'b0}) begin
        n_fail++; $display("FAIL rst_mid_stale[%0d]: got sv=%b ov=%b od=%h want idle", i, sel_valid, out_valid, out_data);
      end
    end
  endtask

  task automatic test_saturate;
    int up_exp;
    up_exp = 16'hFFFD;
    sel_ready = 1'b1;
    out_ready = '1;
    @(negedge CLK);
    force dut.up_count = 16'hFFFD;
    #1 release dut.up_count;
    for (int i = 0; i < 3; i++) begin
      in_data = mk({1'b0, 3'($urandom)});
      in_valid = 1'b1;
      @(negedge CLK); in_valid = 1'b0;
      repeat (3) @(negedge CLK);
      if (up_exp < 16'hFFFF) up_exp++;
      n_checks++;
      if (up_count !== 16'(up_exp)) begin
        n_fail++; $display("FAIL sat_up_count[%0d]: got %h want %h", i, up_count, 16'(up_exp));
      end
    end
  endtask

  task automatic test_random;
    logic [8:0] mq [$];
    int up_exp, deliv;
    logic ps, po;
    logic [1:0] psd;
    logic [2:0] pov;
    logic [8:0] pod;
    up_exp = 0;
    deliv = 0;
    ps = 1'b0;
    po = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLK);
      n_checks++;
      if (in_ready !== (mq.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready@%0d: got %b want %b", c, in_ready, mq.size() < 2); end
      n_checks++;
      if (out_data !== (mq.size() > 0 ? mq[0] : 9'd0)) begin n_fail++; $display("FAIL rnd_out_data@%0d: got %h want %h", c, out_data, mq.size() > 0 ? mq[0] : 9'd0); end
      n_checks++;
      if ((sel_valid && out_valid != 3'b0) !== 1'b0) begin n_fail++; $display("FAIL rnd_exclusive@%0d: got sv=%b ov=%b", c, sel_valid, out_valid); end
      n_checks++;
      if (up_count !== 16'(up_exp)) begin n_fail++; $display("FAIL rnd_up_count@%0d: got %0d want %0d", c, up_count, up_exp); end
      if (sel_valid) begin
        n_checks++;
        if (mq.size() == 0 || sel_data !== 2'(ref_route(mq[0], 2, 2))) begin
          n_fail++; $display("FAIL rnd_sel_data@%0d: got %0d queued=%0d", c, sel_data, mq.size());
        end
      end
      if (out_valid != 3'b0) begin
        n_checks++;
        if (mq.size() == 0 || out_valid !== 3'(1 << ref_route(mq[0], 2, 2))) begin
          n_fail++; $display("FAIL rnd_out_valid@%0d: got %b queued=%0d", c, out_valid, mq.size());
        end
      end
      if (ps) begin
        n_checks++;
        if ({sel_valid, sel_data} !== {1'b1, psd}) begin n_fail++; $display("FAIL rnd_sel_hold@%0d: got %b %0d want 1 %0d", c, sel_valid, sel_data, psd); end
      end
      if (po) begin
        n_checks++;
        if ({out_valid, out_data} !== {pov, pod}) begin n_fail++; $display("FAIL rnd_out_hold@%0d: got %b %h want %b %h", c, out_valid, out_data, pov, pod); end
      end
      in_valid = (c < 560) && ($urandom % 3 != 0);
      in_data = 9'($urandom);
      sel_ready = (c >= 560) || ($urandom % 2 == 0);
      out_ready = (c >= 560) ? 3'b111 : 3'($urandom);
      ps = sel_valid && !sel_ready;
      psd = sel_data;
      po = out_valid != 3'b0 && (out_valid & out_ready) == 3'b0;
      pov = out_valid;
      pod = out_data;
      if ((out_valid & out_ready) != 3'b0 && mq.size() > 0) begin
        if (ref_route(mq[0], 2, 2) == 2 && up_exp < 65535) up_exp++;
        void'(mq.pop_front());
        deliv++;
      end
      if (in_valid && in_ready) mq.push_back(in_data);
    end
    n_checks++;
    if (mq.size() != 0 || deliv < 50) begin
      n_fail++; $display("FAIL rnd_drain: got queued=%0d delivered=%0d want 0 and >=50", mq.size(), deliv);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_backpressure;
    test_hold;
    test_num_out4;
    test_reset_mid;
    test_saturate;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/decoder_n_leaf.md
# decoder_n_leaf

Parametrised NoC routing decoder. It accepts one flit at a time on a valid/ready input, classifies the flit by its address field, and forwards it to one of `NUM_OUT` local down-ports or a single uplink port. For every flit it first issues a select token carrying the chosen port index, then the data flit. It sits at tree nodes and leaves of the NoC. It generalises the fixed 2-way leaf decoder with a configurable port count, address field placement, a 2-entry input buffer for overlap, and an uplink counter.

## Interface
Parameters:
- `DATA_W`, 9: flit width.
- `ADDR_LSB`, 5: LSB position of the address field in the flit.
- `ADDR_W`, 4: address field width; `ADDR_LSB + ADDR_W <= DATA_W`.
- `NUM_OUT`, 2: number of down-ports; a power of two, 2..16.
- `IDX_LSB`, 2: LSB of the port-index sub-field within the address; `IDX_LSB + log2(NUM_OUT) <= ADDR_W`.
- `BASE`, 4'b1000: address prefix owned by this node.
- `MASK`, 4'b1000: prefix mask.
- Derived `SEL_W` = clog2(`NUM_OUT`+1); port `NUM_OUT` is the uplink.

Ports:
- `CLK`  in  1  clock; everything is sampled on the rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `in_data`  in  `DATA_W`  input flit.
- `in_valid`  in  1  input flit valid.
- `in_ready`  out  1  input can accept a flit.
- `sel_data`  out  `SEL_W`  chosen port index.
- `sel_valid`  out  1  select token valid.
- `sel_ready`  in  1  select token consumer ready.
- `out_data`  out  `DATA_W`  flit, shared by all ports.
- `out_valid`  out  `NUM_OUT`+1  one-hot port valid.
- `out_ready`  in  `NUM_OUT`+1  per-port ready.
- `up_count`  out  16  number of flits sent to the uplink; saturating.

## Operation
- Address field: A = `in_data[ADDR_LSB+ADDR_W-1:ADDR_LSB]`, evaluated on the flit at the FIFO head.
- Route function:
  - If (A & `MASK`) != `BASE`, route = `NUM_OUT` (uplink).
  - Otherwise route = A[`IDX_LSB` +: log2(`NUM_OUT`)].
- Input FIFO:
  - 2 entries; `in_ready` = not full, with no combinational path from any ready input.
  - Push happens on `in_valid & in_ready`.
  - Pop happens on the data handshake.
  - A push and a pop in the same cycle are both performed.
- FSM states: IDLE, SEL, DATA.
  - IDLE: if the FIFO is non-empty, register route(head) into `route_q` and go to SEL.
  - SEL: `sel_valid`=1 and `sel_data`=`route_q`. On `sel_ready`, go to DATA.
  - DATA: `out_valid[route_q]`=1 and `out_data`=head. On `out_ready[route_q]`:
    - pop the FIFO;
    - if `route_q`==`NUM_OUT`, increment `up_count` (it saturates at 16'hFFFF);
    - if the FIFO still holds an entry after the pop, register route(next head) and go straight to SEL; otherwise go to IDLE.
- Readies on non-selected ports are ignored.
- `out_data` equals the head entry whenever the FIFO is non-empty, and is 0 when it is empty.
- Reset values:
  - FSM = IDLE and the FIFO is empty.
  - `in_ready`=1.
  - `sel_valid`=0, `sel_data`=0.
  - `out_valid`=0, `out_data`=0.
  - `up_count`=0, `route_q`=0.
- Reset mid-operation: any flit in flight or buffered is discarded, and all outputs return to their reset values asynchronously.

## Timing
- A flit accepted at edge k is visible at the FIFO head after edge k. The FSM leaves IDLE at edge k+1, and `sel_valid` is high in the cycle after edge k+1.
- With all readies held at 1:
  - select handshake at edge k+2;
  - `out_valid` high in the cycle after k+2;
  - data handshake at edge k+3.
  - Latency from input acceptance to data delivery is therefore 3 cycles.
- Steady-state throughput is 1 flit per 2 cycles (SEL then DATA, with no IDLE bubble while the FIFO is non-empty).
- `sel_valid` and `out_valid` are never high in the same cycle.
- Once raised, `sel_valid` and `out_valid` remain high with stable data until their handshake completes.
- Backpressure: while the FSM is stalled in SEL or DATA, the FIFO fills. `in_ready` drops the cycle after the second push, and the third flit is held upstream.

## Test plan
- Defaults; send flits with A=4'b1010 and A=4'b1110 with all readies at 1 -> `sel_data`=0 then `out_valid`=3'b001, followed by `sel_data`=1 then `out_valid`=3'b010. Each flit is delivered 3 cycles after acceptance and the data is unchanged.
- A=4'b0110 -> `sel_data`=2, `out_valid`=3'b100, `up_count` goes from 0 to 1.
- Hold `sel_ready`=0 and push 3 flits -> `in_ready`=0 after the second push. After releasing `sel_ready`, all 3 flits are delivered in order, 2 cycles apart.
- Hold `out_ready[0]`=0 for 5 cycles while a port-0 flit is pending -> `out_valid[0]` and `out_data` stay stable. Toggling `out_ready[1]` has no effect.
- `NUM_OUT`=4, `IDX_LSB`=1, A=4'b1101 -> route 2 and `out_valid`=5'b00100.
- Assert `RESET` while in DATA with 2 flits buffered -> all outputs return to their reset values at once. After release, the first new flit is routed correctly and no stale flit appears. Preload `up_count` near 16'hFFFF -> it saturates.
